// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C display target: FSM states,
// ACK/NACK line levels and the bit-counter width.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK,
    ST_IGNORE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned BIT_CNT_W = 4;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
  localparam bit_cnt_t BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus a history stage that yields
// SCL edges and START/STOP conditions.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] first sync stage, [1] synchronized value, [2] previous value
  logic [2:0] r_scl_sr;
  logic [2:0] r_sda_sr;
  logic       w_scl_high;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sr <= '1;
      r_sda_sr <= '1;
    end else begin
      r_scl_sr <= {r_scl_sr[1:0], scl};
      r_sda_sr <= {r_sda_sr[1:0], sda};
    end
  end

  assign w_scl_high = r_scl_sr[1] & r_scl_sr[2];
  assign scl_rise   = r_scl_sr[1] & ~r_scl_sr[2];
  assign scl_fall   = ~r_scl_sr[1] & r_scl_sr[2];
  assign start_det  = w_scl_high & r_sda_sr[2] & ~r_sda_sr[1];
  assign stop_det   = w_scl_high & ~r_sda_sr[2] & r_sda_sr[1];
  assign sda_s      = r_sda_sr[1];

endmodule

// File: rtl/i2c_display_target.sv
// I2C target exposing a NUM_REGS byte register window: writes leave through
// a strobe port, reads come back through a combinational lookup port.
module i2c_display_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR = 7'h3C,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned PW      = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  inout  wire           sda,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [PW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

  i2c_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start_det(w_start),
    .stop_det (w_stop),
    .sda_s    (w_sda_s)
  );

  state_t        r_state, w_state_nx;
  bit_cnt_t      r_cnt, w_cnt_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [PW-1:0] r_ptr, w_ptr_nx;
  logic          r_sda_oe, w_oe_nx;
  logic          r_busy, w_busy_nx;
  logic          r_wr_stb, w_stb_nx;
  logic [PW-1:0] r_wr_addr, w_waddr_nx;
  logic [7:0]    r_wr_data, w_wdata_nx;
  logic [7:0]    w_byte;

  assign w_byte = {r_shift[6:0], w_sda_s};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_ptr_nx   = r_ptr;
    w_oe_nx    = r_sda_oe;
    w_busy_nx  = r_busy;
    w_stb_nx   = 1'b0;
    w_waddr_nx = r_wr_addr;
    w_wdata_nx = r_wr_data;

    if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx = ST_ADDR;
      w_cnt_nx   = '0;
      w_oe_nx    = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise && r_cnt != BITS_PER_BYTE) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            if (r_state == ST_WDATA && r_cnt == BITS_PER_BYTE - 4'd1) begin
              w_stb_nx   = 1'b1;
              w_waddr_nx = r_ptr;
              w_wdata_nx = w_byte;
            end
          end else if (w_scl_fall && r_cnt == BITS_PER_BYTE) begin
            w_cnt_nx = '0;
            case (r_state)
              ST_ADDR: begin
                if (r_shift[7:1] == I2C_ADDR) begin
                  w_state_nx = ST_ADDR_ACK;
                  w_oe_nx    = 1'b1;
                  w_busy_nx  = 1'b1;
                end else begin
                  w_state_nx = ST_IGNORE;
                  w_busy_nx  = 1'b0;
                end
              end
              ST_PTR: begin
                w_ptr_nx   = r_shift[PW-1:0];
                w_state_nx = ST_PTR_ACK;
                w_oe_nx    = 1'b1;
              end
              default: begin
                w_state_nx = ST_WDATA_ACK;
                w_oe_nx    = 1'b1;
              end
            endcase
          end
        end

        // r_shift still holds the address byte, so bit 0 is the R/W flag
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nx = '0;
            if (r_shift[0]) begin
              w_state_nx = ST_RDATA;
              w_shift_nx = rd_data;
              w_oe_nx    = ~rd_data[7];
            end else begin
              w_state_nx = ST_PTR;
              w_oe_nx    = 1'b0;
            end
          end
        end

        ST_PTR_ACK: begin
          if (w_scl_fall) begin
            w_state_nx = ST_WDATA;
            w_cnt_nx   = '0;
            w_oe_nx    = 1'b0;
          end
        end

        ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nx = ST_WDATA;
            w_cnt_nx   = '0;
            w_oe_nx    = 1'b0;
            w_ptr_nx   = r_ptr + PW'(1);
          end
        end

        ST_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == BITS_PER_BYTE) begin
              w_state_nx = ST_RDATA_MACK;
              w_oe_nx    = 1'b0;
            end else begin
              w_shift_nx = {r_shift[6:0], 1'b0};
              w_oe_nx    = ~r_shift[6];
            end
          end
        end

        // Pointer advances on the controller ACK; the reload on the next
        // fall then sees rd_data for the new pointer.
        ST_RDATA_MACK: begin
          if (w_scl_rise) begin
            if (w_sda_s == I2C_NACK) begin
              w_state_nx = ST_IGNORE;
            end else begin
              w_ptr_nx = r_ptr + PW'(1);
            end
          end else if (w_scl_fall) begin
            w_state_nx = ST_RDATA;
            w_cnt_nx   = '0;
            w_shift_nx = rd_data;
            w_oe_nx    = ~rd_data[7];
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_shift   <= w_shift_nx;
      r_ptr     <= w_ptr_nx;
      r_sda_oe  <= w_oe_nx;
      r_busy    <= w_busy_nx;
      r_wr_stb  <= w_stb_nx;
      r_wr_addr <= w_waddr_nx;
      r_wr_data <= w_wdata_nx;
    end
  end

  assign sda     = r_sda_oe ? 1'b0 : 1'bz;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_display_target.sv
// Scoreboard bench for i2c_display_target: a bit-banged I2C controller drives
// transactions, expected writes and read bytes are queued and compared.
module tb_i2c_display_target;
  import i2c_target_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       tb_low = 1'b0;
  wire        sda;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] regs [16];

  assign sda = tb_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  i2c_display_target #(.I2C_ADDR(7'h3C), .NUM_REGS(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .scl    (scl),
    .sda    (sda),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy)
  );

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         stb_cnt = 0;
  int         pull_cnt = 0;
  logic       prev_stb = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: pops the expected write for each strobe.
  always @(negedge clk) begin
    if (sda === 1'b0 && !tb_low) pull_cnt++;
    if (wr_stb) begin
      stb_cnt++;
      check_eq("stb_width", 32'(prev_stb), 32'd0);
      if (wq.size() == 0) begin
        check_eq("stb_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check_eq("wr_addr", 32'(wr_addr), 32'(e.a));
        check_eq("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
    prev_stb = wr_stb;
  end

  task automatic q_wait();
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    tb_low = ~v;
    q_wait(); scl = 1'b1; q_wait(); q_wait(); scl = 1'b0; q_wait();
  endtask

  task automatic read_bit(output logic v);
    tb_low = 1'b0;
    q_wait(); scl = 1'b1; q_wait(); v = sda; q_wait(); scl = 1'b0; q_wait();
  endtask

  task automatic i2c_start();
    tb_low = 1'b0;
    q_wait(); scl = 1'b1; q_wait(); tb_low = 1'b1; q_wait(); scl = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    tb_low = 1'b1;
    q_wait(); scl = 1'b1; q_wait(); tb_low = 1'b0; q_wait(); q_wait();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_bit(ack_n);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    send_bit(nack);
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    logic [2:0] part;
    int         snap_stb, snap_pull;

    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 16 + 7);
    repeat (5) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stb", 32'(wr_stb), 32'd0);
    check_eq("rst_waddr", 32'(wr_addr), 32'd0);
    check_eq("rst_wdata", 32'(wr_data), 32'd0);
    check_eq("rst_ptr", 32'(rd_addr), 32'd0);
    check_eq("rst_sda", 32'(sda), 32'd1);
    reset = 1'b0;
    q_wait();

    // Write burst at pointer 5
    i2c_start();
    wr_byte(8'h78, a); check_eq("wb_addr_ack", 32'(a), 32'(I2C_ACK));
    check_eq("wb_busy", 32'(busy), 32'd1);
    wr_byte(8'h05, a); check_eq("wb_ptr_ack", 32'(a), 32'(I2C_ACK));
    wq.push_back('{a: 4'd5, d: 8'hA1});
    wr_byte(8'hA1, a); check_eq("wb_d0_ack", 32'(a), 32'(I2C_ACK));
    wq.push_back('{a: 4'd6, d: 8'hB2});
    wr_byte(8'hB2, a); check_eq("wb_d1_ack", 32'(a), 32'(I2C_ACK));
    i2c_stop();
    check_eq("wb_busy_after_stop", 32'(busy), 32'd0);
    check_eq("wb_ptr", 32'(rd_addr), 32'd7);

    // Random read: pointer 3, repeated START, two bytes
    regs[3] = 8'h11; regs[4] = 8'h22;
    i2c_start();
    wr_byte(8'h78, a); check_eq("rr_addr_ack", 32'(a), 32'(I2C_ACK));
    wr_byte(8'h03, a); check_eq("rr_ptr_ack", 32'(a), 32'(I2C_ACK));
    i2c_start();
    wr_byte(8'h79, a); check_eq("rr_raddr_ack", 32'(a), 32'(I2C_ACK));
    rq.push_back(8'h11); rq.push_back(8'h22);
    rd_byte(1'b0, b); check_eq("rr_byte0", 32'(b), 32'(rq.pop_front()));
    rd_byte(1'b1, b); check_eq("rr_byte1", 32'(b), 32'(rq.pop_front()));
    snap_pull = pull_cnt;
    q_wait();
    check_eq("rr_released", 32'(pull_cnt - snap_pull), 32'd0);
    i2c_stop();
    check_eq("rr_ptr", 32'(rd_addr), 32'd4);

    // Wrong address
    snap_stb = stb_cnt; snap_pull = pull_cnt;
    i2c_start();
    wr_byte(8'h7A, a); check_eq("wa_nack", 32'(a), 32'(I2C_NACK));
    wr_byte(8'h00, a); check_eq("wa_data_nack", 32'(a), 32'(I2C_NACK));
    i2c_stop();
    check_eq("wa_no_pull", 32'(pull_cnt - snap_pull), 32'd0);
    check_eq("wa_no_stb", 32'(stb_cnt - snap_stb), 32'd0);
    check_eq("wa_busy", 32'(busy), 32'd0);

    // Pointer wrap 15 -> 0 -> 1
    i2c_start();
    wr_byte(8'h78, a); check_eq("pw_addr_ack", 32'(a), 32'(I2C_ACK));
    wr_byte(8'h0F, a);
    wq.push_back('{a: 4'd15, d: 8'h3C});
    wq.push_back('{a: 4'd0,  d: 8'hC3});
    wq.push_back('{a: 4'd1,  d: 8'h5A});
    wr_byte(8'h3C, a); wr_byte(8'hC3, a); wr_byte(8'h5A, a);
    check_eq("pw_last_ack", 32'(a), 32'(I2C_ACK));
    i2c_stop();
    check_eq("pw_ptr", 32'(rd_addr), 32'd2);

    // Abort: STOP after 5 data bits
    snap_stb = stb_cnt;
    i2c_start();
    wr_byte(8'h78, a);
    wr_byte(8'h02, a);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    i2c_stop();
    check_eq("ab_no_stb", 32'(stb_cnt - snap_stb), 32'd0);
    check_eq("ab_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check_eq("ab_busy", 32'(busy), 32'd0);
    check_eq("ab_ptr", 32'(rd_addr), 32'd2);

    // Repeated START in the middle of a read byte
    regs[2] = 8'h1F;
    i2c_start();
    wr_byte(8'h79, a); check_eq("ar_raddr_ack", 32'(a), 32'(I2C_ACK));
    for (int i = 2; i >= 0; i--) begin
      read_bit(a);
      part[i] = a;
    end
    check_eq("ar_partial", 32'(part), 32'd0);
    i2c_start();
    check_eq("ar_oe_released", 32'(dut.r_sda_oe), 32'd0);
    wr_byte(8'h78, a); check_eq("ar_new_addr_ack", 32'(a), 32'(I2C_ACK));
    wr_byte(8'h09, a);
    i2c_stop();
    check_eq("ar_ptr", 32'(rd_addr), 32'd9);

    // Reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h78 >> i));
    tb_low = 1'b0;
    q_wait();
    check_eq("rs_acking", 32'(sda), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rs_sda_released", 32'(sda), 32'd1);
    check_eq("rs_ptr", 32'(rd_addr), 32'd0);
    check_eq("rs_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    q_wait(); scl = 1'b1; q_wait(); scl = 1'b0; q_wait();
    i2c_stop();
    i2c_start();
    wr_byte(8'h78, a); check_eq("rs_next_ack", 32'(a), 32'(I2C_ACK));
    wr_byte(8'h00, a);
    wq.push_back('{a: 4'd0, d: 8'h96});
    wr_byte(8'h96, a); check_eq("rs_data_ack", 32'(a), 32'(I2C_ACK));
    i2c_stop();

    check_eq("sb_writes_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_display_target.md
# i2c_display_target

I2C target (responder) with a 16-entry byte register window, the far end of the I2C link driven by the SoC's Wishbone display controller. It sits on a display-side board or in the SoC testbench as the device model. It decodes START/STOP, matches a 7-bit device address, accepts a register pointer plus write data, and returns read data. Write data leaves the block through a strobe port. Read data enters the block through a combinational lookup port.

## Interface
- `I2C_ADDR`, default `7'h3C`: 7-bit device address the block answers to.
- `NUM_REGS`, default `16`: register window size; must be a power of two, 2..256. The pointer width `PW` is clog2(`NUM_REGS`).

- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `scl` in 1: I2C clock from the controller; the block never stretches SCL.
- `sda` inout 1: open-drain data line; driven `0` when `sda_oe`, else `z`.
- `wr_stb` out 1: one-cycle pulse; `wr_addr`/`wr_data` are valid in the same cycle.
- `wr_addr` out PW: register index being written.
- `wr_data` out 8: byte being written.
- `rd_addr` out PW: current pointer, for read lookup.
- `rd_data` in 8: combinational register contents at `rd_addr`.
- `busy` out 1: high from an address-matched ACK until STOP or a non-matching address.

## Operation
- **Line sync**
  - `scl` and `sda` each pass through a 2-flop synchronizer.
  - A third flop stage gives previous-value edge detection.
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
  - Data bits are sampled on the `scl` rise.
  - `sda_oe` changes only on the cycle after an `scl` fall.
- **FSM states**
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits (7 address + R/W, MSB first).
  - ADDR_ACK
  - PTR
  - PTR_ACK
  - WDATA
  - WDATA_ACK
  - RDATA
  - RDATA_MACK
  - IGNORE
- **Address byte**
  - Match: drive ACK (`sda_oe=1`) from the `scl` fall after bit 8 until the next `scl` fall. `busy` is set.
  - R/W=0: go to PTR.
  - R/W=1: load the shift register from `rd_data`, then go to RDATA.
  - Mismatch: no ACK; go to IGNORE.
- **PTR**: the received byte's low PW bits become the pointer. ACK, then go to WDATA.
- **WDATA**
  - Each complete byte pulses `wr_stb` on the `scl` rise of bit 8, with `wr_addr`=pointer.
  - The block ACKs the byte, then increments the pointer.
- **RDATA**
  - Drive `sda_oe = ~shift[7]` after each `scl` fall.
  - After 8 bits, release `sda` and sample the controller's ACK on the 9th `scl` rise.
  - ACK: pointer++, reload from `rd_data`, continue.
  - NACK: go to IGNORE.
- **Pointer**: increments modulo `NUM_REGS` (wraps from `NUM_REGS`-1 to 0). It persists across transactions and repeated START. It clears only on reset.
- **START in any state** (repeated START): abort the current byte, release `sda`, and go to ADDR. A partial byte is discarded with no `wr_stb`.
- **STOP in any state**: go to IDLE, release `sda`, clear `busy`.
- **Reset values**: `sda_oe=0`, `wr_stb=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, pointer=0, FSM=IDLE, synchronizer flops=1.
- **Reset mid-transfer**: the line is released the next cycle. The rest of the bus transaction is ignored until a new START.

## Timing
- Input latency: 3 `clk` from a pin edge to its detected event.
- `sda_oe` update: 1 `clk` after the detected `scl` fall.
- `clk` must be at least 16× the `scl` frequency.
  - 100 kHz and 400 kHz are supported at a `clk` of 6.4 MHz or more.
- `wr_stb` fires 1 `clk` after the detected 8th `scl` rise and lasts exactly 1 cycle.
- `rd_data` is sampled in the same cycle the shift register loads.
  - Host logic must present it combinationally from `rd_addr`.
- No glitch filter.
  - Noise shorter than 2 `clk` may be captured; board-level filtering is required.

## Structure
- Package `i2c_target_pkg`:
  - FSM state enum
  - `I2C_ACK` / `I2C_NACK` constants
  - bit-count width (4)
- Sub-module `i2c_line_sync`:
  - synchronizers
  - edge detection
  - outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`
- The top level holds the FSM, bit counter, shift register and pointer, roughly 200 lines total.

## Test plan
- **Write burst**: START, `0x78`, `0x05`, `0xA1`, `0xB2`, STOP → ACK on all 4 bytes; `wr_stb` at addresses 5 and 6 with data `A1` and `B2`; `busy` falls after STOP.
- **Random read**: write pointer 3, repeated START, `0x79`, read 2 bytes with regs[3]=`0x11` and regs[4]=`0x22`, controller NACKs the last byte → `sda` carries `11` then `22`; `sda` is released after the NACK.
- **Wrong address**: START, `0x7A`, … → no ACK, no `wr_stb`, `sda_oe` stays 0 until STOP.
- **Pointer wrap**: pointer 15, write 3 bytes → `wr_addr` sequence 15, 0, 1.
- **Abort**: STOP after 5 bits of a data byte → no `wr_stb`, FSM=IDLE. Then START mid-byte in RDATA → `sda` released within 1 cycle, new address accepted.
- **Reset mid-ACK**: assert `reset` while `sda_oe`=1 → `sda_oe`=0 the next cycle, pointer=0; the next full transaction works.
